// File: rtl/pc_sequencer_if.sv
// Fetch/execute handshake and PC bus shared between the sequencer and its
// instruction memory / execute stage.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        exec_done;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        jalr;
  logic [31:0] PC_Target;
  logic [31:0] ALUResult;
  logic [1:0]  PCSrc;
  logic [31:0] PC;
  logic [31:0] PC_Plus_4;
  logic        misaligned;
  logic [31:0] retire_count;

  modport master (
    output imem_req, imem_addr, instr_valid, PCSrc, PC, PC_Plus_4,
           misaligned, retire_count,
    input  imem_ack, exec_done, stall, branch_taken, jump, jalr,
           PC_Target, ALUResult
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, PCSrc, PC, PC_Plus_4,
           misaligned, retire_count,
    output imem_ack, exec_done, stall, branch_taken, jump, jalr,
           PC_Target, ALUResult
  );
endinterface

// File: rtl/pc_sequencer.sv
// Two-state fetch/execute sequencer owning the program counter, the
// misaligned-target trap and the retired-instruction counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t      state;
  state_t      state_next;
  logic        retire;
  logic [1:0]  pc_src;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [31:0] candidate;
  logic [31:0] count;
  logic        mis;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      FETCH: if (bus.imem_ack) state_next = EXEC;
      EXEC: begin
        if (bus.exec_done && !bus.stall) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // jalr outranks jump/branch; code 2'b11 is never produced
  always_comb begin
    pc_src = 2'b00;
    if (!reset && state == EXEC) begin
      if (bus.jalr)                          pc_src = 2'b10;
      else if (bus.jump || bus.branch_taken) pc_src = 2'b01;
    end
  end

  assign pc_plus_4 = pc + 32'd4;

  always_comb begin
    case (pc_src)
      2'b01:   candidate = bus.PC_Target;
      2'b10:   candidate = {bus.ALUResult[31:1], 1'b0};
      default: candidate = pc_plus_4;
    endcase
  end

  // Reset wins over a coincident retire, so an abandoned instruction never counts
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_VECTOR;
      mis   <= 1'b0;
      count <= 32'd0;
    end else if (retire) begin
      count <= count + 32'd1;
      if (candidate[1:0] == 2'b00) begin
        pc <= candidate;
      end else begin
        pc  <= TRAP_VECTOR;
        mis <= 1'b1;
      end
    end
  end

  assign bus.imem_req     = !reset && (state == FETCH);
  assign bus.instr_valid  = !reset && (state == EXEC);
  assign bus.imem_addr    = pc;
  assign bus.PCSrc        = pc_src;
  assign bus.PC           = pc;
  assign bus.PC_Plus_4    = pc_plus_4;
  assign bus.misaligned   = mis;
  assign bus.retire_count = count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: every retire pushes the model's expected
// PC / count / misaligned triple, which is popped once the retire edge passes.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;

  task automatic idle_inputs();
    bus.imem_ack     = 1'b0;
    bus.exec_done    = 1'b0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.jalr         = 1'b0;
    bus.PC_Target    = 32'h0;
    bus.ALUResult    = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_pc  = 32'h0;
    m_cnt = 32'h0;
    m_mis = 1'b0;
    sb.delete();
    #1;
  endtask

  // From FETCH at a negedge: ack on fetch cycle wait_cycles+1, end in EXEC at a negedge
  task automatic fetch(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      bus.imem_ack = 1'b0;
      @(negedge clk);
    end
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #1;
  endtask

  // Model of one retire: updates m_* and pushes the expected result
  task automatic push_expected(input logic jmp, input logic br, input logic jr,
                               input logic [31:0] tgt, input logic [31:0] alu);
    logic [31:0] cand;
    exp_t        x;
    if (jr)             cand = alu & 32'hFFFF_FFFE;
    else if (jmp || br) cand = tgt;
    else                cand = m_pc + 32'd4;
    if (cand[1:0] != 2'b00) begin
      m_pc  = 32'h0000_0100;
      m_mis = 1'b1;
    end else begin
      m_pc = cand;
    end
    m_cnt  = m_cnt + 32'd1;
    x.pc   = m_pc;
    x.cnt  = m_cnt;
    x.mis  = m_mis;
    sb.push_back(x);
  endtask

  // Drive a retiring EXEC cycle and advance to the following negedge
  task automatic retire_with(input logic jmp, input logic br, input logic jr,
                             input logic [31:0] tgt, input logic [31:0] alu);
    bus.jump         = jmp;
    bus.branch_taken = br;
    bus.jalr         = jr;
    bus.PC_Target    = tgt;
    bus.ALUResult    = alu;
    bus.exec_done    = 1'b1;
    bus.stall        = 1'b0;
    push_expected(jmp, br, jr, tgt, alu);
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  task automatic pop_entry(output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
  endtask

  task automatic test_reset();
    bit ok;
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    bus.imem_ack  = 1'b1;
    bus.exec_done = 1'b1;
    bus.jalr      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.PCSrc !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: req=%b valid=%b pcsrc=%b, required 0/0/00",
               bus.imem_req, bus.instr_valid, bus.PCSrc);
    end
    checks++;
    if (bus.PC !== 32'h0 || bus.retire_count !== 32'h0 || bus.misaligned !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: pc=%h cnt=%0d mis=%b, required 0/0/0",
               bus.PC, bus.retire_count, bus.misaligned);
    end
    do_reset();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_release_req: req=%b addr=%h, required 1/0",
               bus.imem_req, bus.imem_addr);
    end
    ok = 1'b1;
  endtask

  task automatic test_fetch_wait();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = (i == 2);
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fetch_cycle%0d: req=%b addr=%h valid=%b, required 1/0/0",
                 i, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exec_entry: valid=%b req=%b, required 1/0",
               bus.instr_valid, bus.imem_req);
    end
    // ack while executing must not disturb anything
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.PC !== 32'h0 || bus.retire_count !== 32'h0) begin
      errors++;
      $display("[TB] FAIL exec_ack_ignored: valid=%b pc=%h cnt=%0d, required 1/0/0",
               bus.instr_valid, bus.PC, bus.retire_count);
    end
    bus.exec_done = 1'b1;
    #1;
    checks++;
    if (bus.PCSrc !== 2'b00) begin
      errors++;
      $display("[TB] FAIL seq_pcsrc: got %b, required 00", bus.PCSrc);
    end
    retire_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    pop_entry(ok);
    checks++;
    if (!ok || bus.PC !== e.pc || bus.retire_count !== e.cnt || bus.imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_retire: pc=%h cnt=%0d req=%b, required %h/%0d/1",
               bus.PC, bus.retire_count, bus.imem_req, e.pc, e.cnt);
    end
  endtask

  task automatic test_jalr_priority();
    bit ok;
    fetch(0);
    retire_with(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    pop_entry(ok);
    checks++;
    if (!ok || bus.PC !== e.pc) begin
      errors++;
      $display("[TB] FAIL jump_to_40: pc=%h, required %h", bus.PC, e.pc);
    end
    fetch(1);
    bus.branch_taken = 1'b1;
    bus.jalr         = 1'b1;
    bus.PC_Target    = 32'h80;
    bus.ALUResult    = 32'h201;
    #1;
    checks++;
    if (bus.PCSrc !== 2'b10) begin
      errors++;
      $display("[TB] FAIL jalr_pcsrc: got %b, required 10", bus.PCSrc);
    end
    retire_with(1'b0, 1'b1, 1'b1, 32'h80, 32'h201);
    pop_entry(ok);
    checks++;
    if (!ok || bus.PC !== e.pc || e.pc !== 32'h200 || bus.misaligned !== e.mis) begin
      errors++;
      $display("[TB] FAIL jalr_target: pc=%h mis=%b, required 00000200/0", bus.PC, bus.misaligned);
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    fetch(0);
    retire_with(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    pop_entry(ok);
    fetch(0);
    bus.jump      = 1'b1;
    bus.PC_Target = 32'h46;
    #1;
    checks++;
    if (bus.PCSrc !== 2'b01 || bus.PC !== 32'h40) begin
      errors++;
      $display("[TB] FAIL jump_pcsrc: pcsrc=%b pc=%h, required 01/00000040", bus.PCSrc, bus.PC);
    end
    retire_with(1'b1, 1'b0, 1'b0, 32'h46, 32'h0);
    pop_entry(ok);
    checks++;
    if (!ok || bus.PC !== 32'h100 || bus.misaligned !== 1'b1 || bus.retire_count !== e.cnt) begin
      errors++;
      $display("[TB] FAIL misaligned_trap: pc=%h mis=%b cnt=%0d, required 00000100/1/%0d",
               bus.PC, bus.misaligned, bus.retire_count, e.cnt);
    end
    for (int i = 0; i < 3; i++) begin
      fetch(i);
      retire_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      pop_entry(ok);
      checks++;
      if (!ok || bus.PC !== e.pc || bus.misaligned !== e.mis || bus.retire_count !== e.cnt) begin
        errors++;
        $display("[TB] FAIL sticky_mis%0d: pc=%h mis=%b cnt=%0d, required %h/%b/%0d",
                 i, bus.PC, bus.misaligned, bus.retire_count, e.pc, e.mis, e.cnt);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    fetch(0);
    bus.exec_done    = 1'b1;
    bus.stall        = 1'b1;
    bus.branch_taken = 1'b1;
    bus.PC_Target    = 32'h300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.PC !== m_pc || bus.retire_count !== m_cnt || bus.instr_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: pc=%h cnt=%0d valid=%b, required %h/%0d/1",
                 i, bus.PC, bus.retire_count, bus.instr_valid, m_pc, m_cnt);
      end
    end
    retire_with(1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
    pop_entry(ok);
    checks++;
    if (!ok || bus.PC !== e.pc || bus.retire_count !== e.cnt || bus.imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: pc=%h cnt=%0d req=%b, required %h/%0d/1",
               bus.PC, bus.retire_count, bus.imem_req, e.pc, e.cnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.PC !== m_pc || bus.retire_count !== m_cnt) begin
      errors++;
      $display("[TB] FAIL stall_single_update: pc=%h cnt=%0d, required %h/%0d",
               bus.PC, bus.retire_count, m_pc, m_cnt);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    fetch(0);
    retire_with(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
    pop_entry(ok);
    fetch(0);
    checks++;
    if (bus.PC !== 32'hFFFF_FFFC || bus.PC_Plus_4 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_plus4: pc=%h plus4=%h, required fffffffc/00000000",
               bus.PC, bus.PC_Plus_4);
    end
    retire_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    pop_entry(ok);
    checks++;
    if (!ok || bus.PC !== e.pc || e.pc !== 32'h0 || bus.retire_count !== e.cnt) begin
      errors++;
      $display("[TB] FAIL wrap_pc: pc=%h cnt=%0d, required 00000000/%0d",
               bus.PC, bus.retire_count, e.cnt);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    fetch(0);
    retire_with(1'b1, 1'b0, 1'b0, 32'h88, 32'h0);
    pop_entry(ok);
    fetch(0);
    bus.exec_done = 1'b1;
    reset         = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.PC !== 32'h0 || bus.retire_count !== 32'h0 || bus.instr_valid !== 1'b0 ||
        bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_exec: pc=%h cnt=%0d valid=%b req=%b, required 0/0/0/0",
               bus.PC, bus.retire_count, bus.instr_valid, bus.imem_req);
    end
    reset = 1'b0;
    idle_inputs();
    m_pc  = 32'h0;
    m_cnt = 32'h0;
    m_mis = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_to_fetch: req=%b valid=%b, required 1/0",
               bus.imem_req, bus.instr_valid);
    end
    // reset with an outstanding fetch and an ack in the same cycle
    bus.imem_ack = 1'b1;
    reset        = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.retire_count !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_in_fetch: req=%b cnt=%0d, required 1/0",
               bus.imem_req, bus.retire_count);
    end
  endtask

  task automatic test_back_to_back();
    bit          ok;
    logic        jmp, br, jr;
    logic [31:0] tgt, alu;
    for (int i = 0; i < 12; i++) begin
      fetch(int'($urandom_range(0, 2)));
      jmp = 1'($urandom_range(0, 1));
      br  = 1'($urandom_range(0, 1));
      jr  = ($urandom_range(0, 3) == 0);
      tgt = {$urandom_range(0, 32'hFFFF), 14'h0, 2'($urandom_range(0, 3) == 0 ? 2 : 0)};
      alu = {$urandom_range(0, 32'hFFFF), 14'h0, 1'b0, 1'($urandom_range(0, 1))};
      retire_with(jmp, br, jr, tgt, alu);
      pop_entry(ok);
      checks++;
      if (!ok || bus.PC !== e.pc || bus.retire_count !== e.cnt || bus.misaligned !== e.mis) begin
        errors++;
        $display("[TB] FAIL b2b%0d: pc=%h cnt=%0d mis=%b, required %h/%0d/%b",
                 i, bus.PC, bus.retire_count, bus.misaligned, e.pc, e.cnt, e.mis);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    m_pc  = 32'h0;
    m_cnt = 32'h0;
    m_mis = 1'b0;
    test_reset();
    test_fetch_wait();
    test_jalr_priority();
    test_misaligned();
    do_reset();
    test_stall();
    test_wrap();
    test_reset_mid_exec();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
